// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared constants for the integer square-root core.
//   - default radicand width and done-hold length
//   - FSM state encoding used by sqrt_core_ctrl
package sqrt_pkg;

  localparam int SQRT_DEF_WIDTH     = 16;
  localparam int SQRT_DEF_DONE_HOLD = 10;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_LOAD  = 3'd1;
  localparam logic [ST_W-1:0] ST_SHIFT = 3'd2;
  localparam logic [ST_W-1:0] ST_TEST  = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/sqrt_core_ctrl.sv
// sqrt_core_ctrl: sequencing FSM, iteration counter and done-hold timer for
// the restoring square-root datapath in sqrt_core_param.
// Ports:
//   clk, rst      clock, async active-high reset
//   init          start request, only honoured in IDLE with done low
//   accept        one-cycle strobe on the edge that takes a new operand
//   do_load/do_shift/do_test  datapath step enables (state decodes)
//   busy          registered; high from the accept edge until done rises
//   done          registered; high for exactly DONE_HOLD cycles
// Debug: with BENCH defined, state_name decodes the current state.
//
// state | meaning
// IDLE  | waiting for init
// LOAD  | clear rem/root/iteration counter
// SHIFT | bring next two radicand bits into rem
// TEST  | trial subtract, append one root bit
// DONE  | result valid, hold timer running
module sqrt_core_ctrl
  import sqrt_pkg::*;
#(
  parameter int WIDTH     = SQRT_DEF_WIDTH,
  parameter int DONE_HOLD = SQRT_DEF_DONE_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic init,
  output logic accept,
  output logic do_load,
  output logic do_shift,
  output logic do_test,
  output logic busy,
  output logic done
);

  localparam int ITER = WIDTH / 2;
  localparam int CW   = $clog2(ITER + 1);
  localparam int HW   = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] state_nxt;
  logic [CW-1:0]   iter_cnt;
  logic [HW-1:0]   hold_cnt;
  logic            enter_done;

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:  state_nxt = (init && !done) ? ST_LOAD : ST_IDLE;
      ST_LOAD:  state_nxt = ST_SHIFT;
      ST_SHIFT: state_nxt = ST_TEST;
      ST_TEST:  state_nxt = (iter_cnt == CW'(ITER - 1)) ? ST_DONE : ST_SHIFT;
      ST_DONE:  state_nxt = (hold_cnt == '0) ? ST_IDLE : ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // done lags DONE by one cycle, so IDLE must also wait for it to drop;
  // otherwise init in the trailing done cycle would start a new operation.
  assign accept     = (state == ST_IDLE) && init && !done;
  assign do_load    = (state == ST_LOAD);
  assign do_shift   = (state == ST_SHIFT);
  assign do_test    = (state == ST_TEST);
  assign enter_done = (state == ST_TEST) && (state_nxt == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      iter_cnt <= '0;
      hold_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;

      if (do_load)
        iter_cnt <= '0;
      else if (do_test)
        iter_cnt <= iter_cnt + CW'(1);

      // down-counter: loaded on DONE entry, DONE exits at terminal count
      if (enter_done)
        hold_cnt <= HW'(DONE_HOLD - 1);
      else if ((state == ST_DONE) && (hold_cnt != '0))
        hold_cnt <= hold_cnt - HW'(1);

      // busy stays up through the first DONE cycle so busy/done hand over
      // with no gap in which the core looks idle but is not.
      busy <= (state_nxt == ST_LOAD) || (state_nxt == ST_SHIFT) ||
              (state_nxt == ST_TEST) || enter_done;
      done <= (state == ST_DONE);
    end
  end

`ifdef BENCH
  logic [8*5-1:0] state_name;
  always_comb begin
    state_name = "?????";
    case (state)
      ST_IDLE:  state_name = "IDLE ";
      ST_LOAD:  state_name = "LOAD ";
      ST_SHIFT: state_name = "SHIFT";
      ST_TEST:  state_name = "TEST ";
      ST_DONE:  state_name = "DONE ";
      default:  state_name = "?????";
    endcase
  end
`endif

endmodule

// File: rtl/sqrt_core_param.sv
// sqrt_core_param: unsigned integer square root, one result bit per
// SHIFT/TEST pair (restoring digit-by-digit method).
// Ports:
//   clk, rst      clock, async active-high reset
//   init          start request (level, honoured only when idle)
//   radicand      WIDTH-bit operand, captured on the accept edge
//   root          WIDTH/2-bit floor(sqrt(radicand)), held until next LOAD
//   busy, done    status from sqrt_core_ctrl
//   remainder     (only with SQRT_CORE_REM_EN) radicand - root^2
// Parameters: WIDTH (even, >= 4), DONE_HOLD (>= 1).
// Optional feature macro: SQRT_CORE_REM_EN.
module sqrt_core_param
  import sqrt_pkg::*;
#(
  parameter int WIDTH     = SQRT_DEF_WIDTH,
  parameter int DONE_HOLD = SQRT_DEF_DONE_HOLD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic [WIDTH-1:0]   radicand,
  output logic [WIDTH/2-1:0] root,
  output logic               busy,
  output logic               done
`ifdef SQRT_CORE_REM_EN
  ,
  output logic [WIDTH/2:0]   remainder
`endif
);

  localparam int HALF = WIDTH / 2;
  localparam int RW   = HALF + 2;

  logic             accept;
  logic             do_load;
  logic             do_shift;
  logic             do_test;
  logic [WIDTH-1:0] rad;
  logic [RW-1:0]    rem;
  logic [RW-1:0]    trial;

  sqrt_core_ctrl #(
    .WIDTH     (WIDTH),
    .DONE_HOLD (DONE_HOLD)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .init     (init),
    .accept   (accept),
    .do_load  (do_load),
    .do_shift (do_shift),
    .do_test  (do_test),
    .busy     (busy),
    .done     (done)
  );

  assign trial = {root, 2'b01};

  // rad is taken on the accept edge so later radicand changes are harmless.
  // The top two rem bits dropped by the shift are always zero: rem never
  // exceeds 2*root, which fits in HALF+1 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rad  <= '0;
      rem  <= '0;
      root <= '0;
    end else begin
      if (accept)
        rad <= radicand;
      else if (do_shift)
        rad <= {rad[WIDTH-3:0], 2'b00};

      if (do_load) begin
        rem  <= '0;
        root <= '0;
      end else if (do_shift) begin
        rem <= {rem[RW-3:0], rad[WIDTH-1 -: 2]};
      end else if (do_test) begin
        if (rem >= trial) begin
          rem  <= rem - trial;
          root <= {root[HALF-2:0], 1'b1};
        end else begin
          root <= {root[HALF-2:0], 1'b0};
        end
      end
    end
  end

`ifdef SQRT_CORE_REM_EN
  assign remainder = rem[HALF:0];
`endif

endmodule

// File: tb/tb_sqrt_core_param.sv
module tb_sqrt_core_param;

  typedef struct {
    longint v;
    longint r;
    longint m;
    longint acc;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // instance A: WIDTH=16, DONE_HOLD=10
  logic        rst_a, init_a, busy_a, done_a;
  logic [15:0] rad_a;
  logic [7:0]  root_a;
  // instance B: WIDTH=8, DONE_HOLD=3
  logic        rst_b, init_b, busy_b, done_b;
  logic [7:0]  rad_b;
  logic [3:0]  root_b;
`ifdef SQRT_CORE_REM_EN
  logic [8:0]  rem_a;
  logic [4:0]  rem_b;
`endif

  sqrt_core_param #(.WIDTH(16), .DONE_HOLD(10)) u_a (
    .clk(clk), .rst(rst_a), .init(init_a), .radicand(rad_a),
    .root(root_a), .busy(busy_a), .done(done_a)
`ifdef SQRT_CORE_REM_EN
    , .remainder(rem_a)
`endif
  );

  sqrt_core_param #(.WIDTH(8), .DONE_HOLD(3)) u_b (
    .clk(clk), .rst(rst_b), .init(init_b), .radicand(rad_b),
    .root(root_b), .busy(busy_b), .done(done_b)
`ifdef SQRT_CORE_REM_EN
    , .remainder(rem_b)
`endif
  );

  item_t q_a[$];
  item_t q_b[$];

  // reference: largest r with r*r <= v, by plain search
  function automatic longint isqrt(input longint v);
    longint r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic start_a(input longint v);
    int n = 0;
    item_t it;
    @(negedge clk);
    while ((busy_a || done_a) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("a_idle_timeout", 1, 0);
    init_a = 1'b1;
    rad_a  = 16'(v);
    @(posedge clk);
    #1;
    it.v = v; it.r = isqrt(v); it.m = v - isqrt(v) * isqrt(v); it.acc = cyc;
    q_a.push_back(it);
    init_a = 1'b0;
    rad_a  = 16'($urandom);
    @(negedge clk);
    check("a_busy_after_accept", busy_a, 1);
  endtask

  task automatic start_b(input longint v);
    int n = 0;
    item_t it;
    @(negedge clk);
    while ((busy_b || done_b) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("b_idle_timeout", 1, 0);
    init_b = 1'b1;
    rad_b  = 8'(v);
    @(posedge clk);
    #1;
    it.v = v; it.r = 0; it.m = 0; it.acc = cyc;
    q_b.push_back(it);
    init_b = 1'b0;
    rad_b  = 8'($urandom);
  endtask

  // ---------------- monitors ----------------
  logic  pd_a = 1'b0;
  int    len_a = 0;
  item_t cur_a;

  always @(negedge clk) begin
    if (rst_a) begin
      pd_a  = 1'b0;
      len_a = 0;
    end else begin
      if (done_a && !pd_a) begin
        len_a = 0;
        if (q_a.size() == 0) begin
          check("a_spurious_done", 1, 0);
        end else begin
          cur_a = q_a.pop_front();
          check("a_root", root_a, cur_a.r);
          check("a_latency", cyc - cur_a.acc, 18);
          check("a_busy_at_done", busy_a, 0);
`ifdef SQRT_CORE_REM_EN
          check("a_remainder", rem_a, cur_a.m);
`endif
        end
      end
      if (done_a) len_a++;
      if (!done_a && pd_a) begin
        check("a_done_len", len_a, 10);
        check("a_root_held", root_a, cur_a.r);
      end
      pd_a = done_a;
    end
  end

  logic  pd_b = 1'b0;
  int    len_b = 0;
  item_t cur_b;
  longint rb;

  always @(negedge clk) begin
    if (rst_b) begin
      pd_b  = 1'b0;
      len_b = 0;
    end else begin
      if (done_b && !pd_b) begin
        len_b = 0;
        if (q_b.size() == 0) begin
          check("b_spurious_done", 1, 0);
        end else begin
          cur_b = q_b.pop_front();
          rb = root_b;
          n_vec++;
          if (!((rb * rb <= cur_b.v) && (cur_b.v < (rb + 1) * (rb + 1)))) begin
            n_err++;
            $display("FAIL b_root_bounds: got root %0d for radicand %0d", rb, cur_b.v);
          end
          check("b_latency", cyc - cur_b.acc, 10);
`ifdef SQRT_CORE_REM_EN
          check("b_remainder", rem_b, cur_b.v - rb * rb);
`endif
        end
      end
      if (done_b) len_b++;
      if (!done_b && pd_b) check("b_done_len", len_b, 3);
      pd_b = done_b;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_a = 1'b1; rst_b = 1'b1;
    init_a = 1'b0; init_b = 1'b0;
    rad_a = '0; rad_b = '0;
    #12;
    check("rst_a_root", root_a, 0);
    check("rst_a_busy", busy_a, 0);
    check("rst_a_done", done_a, 0);
    check("rst_b_busy", busy_b, 0);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;

    fork
      begin : thread_a
        start_a(144);
        start_a(65535);
        start_a(2);
        start_a(0);

        // second init while busy must be ignored
        start_a(144);
        repeat (3) @(negedge clk);
        init_a = 1'b1; rad_a = 16'd9;
        repeat (5) @(negedge clk);
        init_a = 1'b0;

        // init throughout the done window must be ignored as well
        n = 0;
        while (!done_a && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("a_done_timeout", 1, 0);
        while (done_a && n < 200) begin
          init_a = 1'b1; rad_a = 16'd9;
          @(negedge clk); n++;
        end
        init_a = 1'b0;
        @(negedge clk);
        check("a_no_restart_after_done", busy_a, 0);

        // async reset mid-operation
        start_a(144);
        repeat (5) @(posedge clk);
        #3 rst_a = 1'b1;
        #1;
        check("a_rst_busy", busy_a, 0);
        check("a_rst_root", root_a, 0);
        check("a_rst_done", done_a, 0);
        q_a.delete();
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        start_a(49);

        repeat (40) start_a(longint'($urandom_range(0, 65535)));
      end
      begin : thread_b
        for (int v = 0; v < 256; v++) start_b(v);
      end
    join

    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || done_a || done_b) && n < 200) begin
      @(negedge clk); n++;
    end
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d vectors expected completion", n_vec);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sqrt_core_param.md
SQRT_CORE_PARAM -- requirements
Module: sqrt_core_param

Interface
REQ-001 Parameter WIDTH, default 16, radicand width in bits; SHALL be even and >= 4.
REQ-002 Parameter DONE_HOLD, default 10, number of cycles done SHALL stay high; SHALL be >= 1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 init  input  1  start request, level-sampled in IDLE only.
REQ-006 radicand  input  WIDTH  operand, captured on the init-accept edge.
REQ-007 root  output  WIDTH/2  floor(sqrt(radicand)), registered.
REQ-008 busy  output  1  high in LOAD, SHIFT and TEST.
REQ-009 done  output  1  result-valid strobe, high only in DONE.

Function
REQ-010 States SHALL be IDLE, LOAD, SHIFT, TEST and DONE; any other encoding SHALL go to IDLE.
REQ-011 IDLE: init=1 -> LOAD; otherwise stay in IDLE.
REQ-012 LOAD: capture radicand into shift register rad; clear rem (WIDTH/2+2 bits), root and the iteration counter; -> SHIFT.
REQ-013 SHIFT: rem <= {rem, rad[WIDTH-1:WIDTH-2]}; rad <<= 2; -> TEST.
REQ-014 TEST: trial = {root, 2'b01} zero-extended to rem width; if rem >= trial, rem <= rem - trial and root <= {root,1}, else root <= {root,0}; counter increments.
REQ-015 TEST -> DONE once WIDTH/2 iterations are complete; otherwise TEST -> SHIFT.
REQ-016 Latency: with init sampled at edge 0, done SHALL rise after edge WIDTH+2 (edge 18 for WIDTH=16) and stay high for exactly DONE_HOLD cycles.
REQ-017 DONE: the hold counter counts DONE_HOLD cycles, then -> IDLE; init SHALL be ignored in DONE.
REQ-018 Result hold: root SHALL hold its final value from DONE entry until the next LOAD.
REQ-019 init while busy or done is high SHALL be ignored; radicand changes after the accept edge SHALL have no effect.
REQ-020 Arithmetic SHALL be unsigned; rem SHALL be WIDTH/2+2 bits wide and SHALL never overflow for any radicand.
REQ-021 radicand=0 SHALL complete with normal latency and give root=0.

Reset
REQ-022 rst=1 SHALL force IDLE immediately, without waiting for a clock edge.
REQ-023 While rst=1: root=0, busy=0, done=0; rem, rad and both counters cleared.
REQ-024 rst asserted mid-operation SHALL abort the operation with no done pulse; the first init after rst deasserts SHALL start a clean operation.

Configuration
REQ-025 Macro SQRT_CORE_REM_EN defined: output port remainder (WIDTH/2+1 bits) SHALL be present and equal radicand - root^2, with the same timing as root (cleared by reset, held until the next LOAD).
REQ-026 SQRT_CORE_REM_EN undefined: the remainder port SHALL be absent; root, busy, done and latency SHALL be unchanged.

Structure
REQ-027 Package sqrt_pkg SHALL hold the state-encoding constants and the default WIDTH and DONE_HOLD values.
REQ-028 The FSM and both counters SHALL be in sub-module sqrt_core_ctrl; the rad/rem/root datapath SHALL be in sqrt_core_param.
REQ-029 With the BENCH macro defined, a state_name debug signal SHALL decode all five states.

Verification
REQ-030 WIDTH=16, radicand=144, init pulse -> done rises 18 cycles after the accept edge; root=12, remainder=0; done high 10 cycles.
REQ-031 radicand=65535 -> root=255, remainder=510; radicand=2 -> root=1, remainder=1.
REQ-032 radicand=0 -> root=0, remainder=0, same latency as REQ-030.
REQ-033 Start radicand=144, then raise init with radicand=9 while busy -> result still 12; exactly one done window.
REQ-034 Assert rst at cycle 5 of an operation, between clock edges -> busy=0 and root=0 immediately, no done; the next init with 49 -> root=7.
REQ-035 WIDTH=8, exhaustive radicands 0..255 -> root^2 <= radicand < (root+1)^2 every time; done rises 10 cycles after each accept edge.
